// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// datapath width and the conditional two's-complement negate helper.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [DIV_WIDTH:1] QUOT_ALL_ONES = {DIV_WIDTH{1'b1}};

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [DIV_WIDTH:1] cond_neg(input logic [DIV_WIDTH:1] v,
                                                    input logic               neg);
        if (neg) begin
            return (~v) + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and keeps the 33-bit trial difference when non-negative.
module div_iter_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:1] partial_rem,
    input  logic           next_bit,
    input  logic [WIDTH:1] divisor_mag,
    output logic [WIDTH:1] new_rem,
    output logic           q_bit
);

    logic [WIDTH+1:1] shifted_s;
    logic [WIDTH+1:1] trial_s;

    // Trial subtraction; the top bit of the difference is its sign.
    always_comb begin
        shifted_s = {partial_rem, next_bit};
        trial_s   = shifted_s - {1'b0, divisor_mag};
        q_bit     = ~trial_s[WIDTH+1];
        if (q_bit) begin
            new_rem = trial_s[WIDTH:1];
        end else begin
            new_rem = shifted_s[WIDTH:1];
        end
    end

endmodule

// File: rtl/seq_divider_32.sv
// 32-bit multi-cycle signed/unsigned divider with start/busy/done handshake.
// Magnitudes are divided one bit per clock, then signs are restored in FIX.
module seq_divider_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [WIDTH:1] dividend,
    input  logic [WIDTH:1] divisor,
    output logic           busy,
    output logic           done,
    output logic [WIDTH:1] quotient,
    output logic [WIDTH:1] remainder,
    output logic           div_by_zero
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    div_state_e       state_r;
    div_state_e       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:1]   rem_r;
    logic [WIDTH:1]   acc_r;
    logic [WIDTH:1]   dmag_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    logic             dbz_r;
    logic             dbz_pending_r;
    logic [WIDTH:1]   quotient_r;
    logic [WIDTH:1]   remainder_r;
    logic             div_by_zero_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH:1]   new_rem_s;
    logic             q_bit_s;
    logic             divisor_zero_s;

    assign divisor_zero_s = (divisor == {WIDTH{1'b0}});

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem (rem_r),
        .next_bit    (acc_r[WIDTH]),
        .divisor_mag (dmag_r),
        .new_rem     (new_rem_s),
        .q_bit       (q_bit_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; the divide-by-zero path spends two cycles in DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = divisor_zero_s ? DONE : RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = RUN;
                end
            end
            FIX:     next_state_s = DONE;
            DONE: begin
                if (dbz_pending_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake outputs, registered one cycle behind the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_r == RUN) || (state_r == FIX) ||
                      ((state_r == DONE) && dbz_pending_r);
            done_r <= (state_r == DONE) && !dbz_pending_r;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r         <= {CNT_W{1'b0}};
            rem_r         <= {WIDTH{1'b0}};
            acc_r         <= {WIDTH{1'b0}};
            dmag_r        <= {WIDTH{1'b0}};
            neg_q_r       <= 1'b0;
            neg_rem_r     <= 1'b0;
            dbz_r         <= 1'b0;
            dbz_pending_r <= 1'b0;
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // A zero divisor keeps the raw dividend for the remainder.
                        acc_r         <= divisor_zero_s ? dividend :
                                         cond_neg(dividend, signed_mode & dividend[WIDTH]);
                        dmag_r        <= cond_neg(divisor, signed_mode & divisor[WIDTH]);
                        rem_r         <= {WIDTH{1'b0}};
                        cnt_r         <= {CNT_W{1'b0}};
                        neg_q_r       <= signed_mode & (dividend[WIDTH] ^ divisor[WIDTH]);
                        neg_rem_r     <= signed_mode & dividend[WIDTH];
                        dbz_r         <= divisor_zero_s;
                        dbz_pending_r <= divisor_zero_s;
                        div_by_zero_r <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r <= new_rem_s;
                    acc_r <= {acc_r[WIDTH-1:1], q_bit_s};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    quotient_r  <= cond_neg(acc_r, neg_q_r);
                    remainder_r <= cond_neg(rem_r, neg_rem_r);
                end
                DONE: begin
                    if (dbz_pending_r) begin
                        quotient_r    <= QUOT_ALL_ONES;
                        remainder_r   <= acc_r;
                        dbz_pending_r <= 1'b0;
                    end else begin
                        div_by_zero_r <= dbz_r;
                    end
                end
                default: begin
                    dbz_pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed/random bench for seq_divider_32 with a reference-model scoreboard,
// latency/busy accounting, ignored-start, back-to-back and async-reset cases.
module tb_seq_divider_32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t last_e;

    seq_divider_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sm);
        exp_t e;
        e.dbz = 1'b0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (!sm) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sm);
        sb_q.push_back(model(a, b, sm));
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("done_low_after_accept", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_done(input int exp_lat, input int exp_busy, input bit glitch);
        int   cyc  = 0;
        int   bcnt = 0;
        exp_t e;
        while (done !== 1'b1 && cyc < 100) begin
            if (glitch && (cyc == 5 || cyc == 20)) begin
                start       = 1'b1;
                signed_mode = 1'b0;
                dividend    = $urandom;
                divisor     = $urandom_range(1, 50);
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (busy === 1'b1) bcnt++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", cyc, exp_lat);
        check("busy_cycles", bcnt, exp_busy);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            last_e = e;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = 32'd0;
        divisor     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(32'd100, 32'd7, 1'b0);
        wait_done(34, 33, 1'b0);
        check("u100_7_q_const", quotient, 32'd14);
        check("u100_7_r_const", remainder, 32'd2);

        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(34, 33, 1'b0);
        check("sneg7_2_q_const", quotient, 32'hFFFF_FFFD);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done(34, 33, 1'b0);
        check("s7_neg2_r_const", remainder, 32'd1);

        issue(32'h1234_5678, 32'd0, 1'b0);
        wait_done(2, 1, 1'b0);
        issue(32'h1234_5678, 32'd0, 1'b1);
        wait_done(2, 1, 1'b0);

        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(34, 33, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(34, 33, 1'b0);

        // Starts during RUN are ignored; the one in the done cycle is taken.
        issue(32'd100, 32'd7, 1'b0);
        wait_done(34, 33, 1'b1);
        issue(32'hFFFF_FC18, 32'd7, 1'b1);
        wait_done(34, 33, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("hold_quotient", quotient, last_e.q);
        check("hold_remainder", remainder, last_e.r);
        check("done_single_pulse", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of RUN.
        issue(32'd12345, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_quotient", quotient, 32'd0);
        check("arst_remainder", remainder, 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        void'(sb_q.pop_front());
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || i == 39) check("no_done_after_abort", {31'd0, done}, 32'd0);
        end
        issue(32'hFFFF_FFFF, 32'd16, 1'b0);
        wait_done(34, 33, 1'b0);
        check("post_rst_q_const", quotient, 32'h0FFF_FFFF);
        check("post_rst_r_const", remainder, 32'd15);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom >> (i * 7)) | 32'd1;
            issue(a, b, i[0]);
            wait_done(34, 33, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
